// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg: shared types and constants for the APB command master
package apb_cmd_master_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDWAIT} state_t;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
    } cmd_t;

    localparam logic [APB_AW-1:0] CNTRL = 'h0;
    localparam logic [APB_AW-1:0] REG1  = 'h4;
    localparam logic [APB_AW-1:0] REG2  = 'h8;
    localparam logic [APB_AW-1:0] REG3  = 'hC;
    localparam logic [APB_AW-1:0] REG4  = 'h10;

endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command, APB and response signals of the command master
interface apb_cmd_master_if
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDRWIDTH = APB_AW,
    parameter int DATAWIDTH = APB_DW
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDRWIDTH-1:0] cmd_addr;
    logic [DATAWIDTH-1:0] cmd_wdata;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic [DATAWIDTH-1:0] PWDATA;
    logic [DATAWIDTH-1:0] PRDATA;
    logic                 rsp_valid;
    logic                 rsp_write;
    logic                 rsp_err;
    logic [DATAWIDTH-1:0] rsp_rdata;
    logic                 busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
        output cmd_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output rsp_valid, rsp_write, rsp_err, rsp_rdata, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
        input  cmd_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  rsp_valid, rsp_write, rsp_err, rsp_rdata, busy
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: synchronous command FIFO, reset flushes pointers and count
module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

    // Pointer/count advance; push is refused while full, pop while empty
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
    end

    // Pointers and count, flushed by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count decides what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: queues write/read commands and issues them as APB transfers
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDRWIDTH = APB_AW,
    parameter int DATAWIDTH = APB_DW,
    parameter int DEPTH     = 4
) (
    input logic              PCLK,
    input logic              PRESETn,
    apb_cmd_master_if.master bus
);
    localparam int CW   = 1 + ADDRWIDTH + DATAWIDTH;
    localparam int CNTW = $clog2(DEPTH) + 1;

    state_t               state_q, state_d;
    logic                 psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
    logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
    logic                 rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CW-1:0]        head;
    logic                 h_write;
    logic [ADDRWIDTH-1:0] h_addr;
    logic [DATAWIDTH-1:0] h_wdata;
    logic                 full, empty, pop, bad, resp_now, launch_ok;
    logic [CNTW-1:0]      count;

    assign {h_write, h_addr, h_wdata} = head;

    apb_cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (bus.cmd_valid),
        .din   ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.cmd_ready = !full && PRESETn;
    assign bus.busy      = count != '0 || state_q != IDLE;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // State and registered bus/response outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Launch decision and next state; a misaligned head is held back while a
    // completion is already being reported so two responses never collide
    always_comb begin
        resp_now  = state_q == RDWAIT || (state_q == ACCESS && pwrite_q);
        bad       = h_addr[1:0] != 2'b00;
        pop       = !empty && (state_q == IDLE || resp_now) && !(bad && resp_now);
        launch_ok = pop && !bad;
        state_d   = state_q == SETUP ? ACCESS :
                    (state_q == ACCESS && !pwrite_q) ? RDWAIT :
                    launch_ok ? SETUP : IDLE;
    end

    // Bus and response values for the next cycle
    always_comb begin
        psel_d      = launch_ok || state_q == SETUP;
        penable_d   = state_q == SETUP;
        pwrite_d    = launch_ok ? h_write : pwrite_q;
        paddr_d     = launch_ok ? h_addr : paddr_q;
        pwdata_d    = launch_ok ? h_wdata : pwdata_q;
        rsp_valid_d = resp_now || (pop && bad);
        rsp_write_d = resp_now ? (state_q == ACCESS) : (pop && bad) ? h_write : rsp_write_q;
        rsp_err_d   = resp_now ? 1'b0 : (pop && bad) ? 1'b1 : rsp_err_q;
        rsp_rdata_d = state_q == RDWAIT ? bus.PRDATA : rsp_valid_d ? '0 : rsp_rdata_q;
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed and randomized checks against a transaction-level model
module tb_apb_cmd_master;
    import apb_cmd_master_pkg::*;

    typedef struct {
        logic        w;
        logic        e;
        logic [31:0] r;
    } rsp_t;

    logic PCLK;
    logic PRESETn;
    int   n_assert;
    int   n_fail;
    int   cyc;

    apb_cmd_master_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus ();

    apb_cmd_master #(.ADDRWIDTH(32), .DATAWIDTH(32), .DEPTH(4)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus.master)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // register slave: no PREADY, read data registered one cycle after ACCESS
    logic [31:0] regs [8];
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            bus.PRDATA <= '0;
        end else if (bus.PSEL && bus.PENABLE) begin
            if (bus.PWRITE) begin
                if (mapped(bus.PADDR)) regs[bus.PADDR[4:2]] <= bus.PWDATA;
            end else begin
                bus.PRDATA <= mapped(bus.PADDR) ? regs[bus.PADDR[4:2]] : 32'h0;
            end
        end
    end

    // model: commands run in order, so results can be computed at push time
    logic [31:0] mmem [8];
    cmd_t        apb_q [$];
    rsp_t        rsp_q [$];

    function automatic bit mapped(input logic [31:0] a);
        return a[1:0] == 2'b00 && a <= 32'h10;
    endfunction

    function automatic void model_push(input logic w, input logic [31:0] a, input logic [31:0] d);
        rsp_t r;
        cmd_t c;
        r.w = w;
        r.e = a[1:0] != 2'b00;
        r.r = '0;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        if (!r.e) begin
            if (w && mapped(a)) mmem[a[4:2]] = d;
            if (!w && mapped(a)) r.r = mmem[a[4:2]];
            apb_q.push_back(c);
        end
        rsp_q.push_back(r);
    endfunction

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        check(act === exp, nm, act, exp);
    endtask

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        int t;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        t = 0;
        while (!bus.cmd_ready && t < 100) begin
            @(negedge PCLK);
            t++;
        end
        if (!bus.cmd_ready) begin
            check(1'b0, "push_timeout", 32'h0, 32'h1);
            bus.cmd_valid = 1'b0;
        end else begin
            model_push(w, a, d);
            @(posedge PCLK);
            #1 bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge PCLK);
            got = bus.rsp_valid;
        end
        if (!got) check(1'b0, "rsp_timeout", 32'h0, 32'h1);
    endtask

    // compare process: APB protocol against queued transfers, responses against model
    initial begin
        cmd_t cur;
        rsp_t r;
        bit   was_setup;
        was_setup = 1'b0;
        cur = '0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                was_setup = 1'b0;
            end else begin
                if (was_setup) begin
                    check(bus.PSEL && bus.PENABLE, "apb_access_phase", {bus.PSEL, bus.PENABLE}, 32'h3);
                    check_eq("apb_addr_stable", bus.PADDR, cur.addr);
                    check_eq("apb_write_stable", bus.PWRITE, cur.write);
                    if (cur.write) check_eq("apb_wdata_stable", bus.PWDATA, cur.wdata);
                end else if (bus.PENABLE) begin
                    check(1'b0, "apb_penable_without_setup", bus.PENABLE, 32'h0);
                end
                if (bus.PSEL && !bus.PENABLE) begin
                    if (apb_q.size() == 0) begin
                        check(1'b0, "apb_unexpected_setup", bus.PADDR, 32'h0);
                    end else begin
                        cur = apb_q.pop_front();
                        check_eq("apb_addr", bus.PADDR, cur.addr);
                        check_eq("apb_write", bus.PWRITE, cur.write);
                        if (cur.write) check_eq("apb_wdata", bus.PWDATA, cur.wdata);
                    end
                end
                was_setup = bus.PSEL && !bus.PENABLE;
                if (bus.rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        check(1'b0, "rsp_unexpected", bus.rsp_rdata, 32'h0);
                    end else begin
                        r = rsp_q.pop_front();
                        check_eq("rsp_write", bus.rsp_write, r.w);
                        check_eq("rsp_err", bus.rsp_err, r.e);
                        check_eq("rsp_rdata", bus.rsp_rdata, r.r);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_full;
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int i = 0; i < 8; i++) mmem[i] = '0;
        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (2) @(negedge PCLK);
        check_eq("reset_psel", bus.PSEL, 1'b0);
        check_eq("reset_penable", bus.PENABLE, 1'b0);
        check_eq("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("reset_busy", bus.busy, 1'b0);
        check_eq("reset_cmd_ready", bus.cmd_ready, 1'b0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check_eq("post_reset_cmd_ready", bus.cmd_ready, 1'b1);

        // write 'h4 <- DEADBEEF from idle: PSEL N+2, PENABLE N+3, rsp N+4
        push(1'b1, 32'h4, 32'hDEADBEEF);
        @(negedge PCLK);
        check_eq("wr_psel_n1", bus.PSEL, 1'b0);
        @(negedge PCLK);
        check_eq("wr_psel_n2", {bus.PSEL, bus.PENABLE}, 2'b10);
        @(negedge PCLK);
        check_eq("wr_penable_n3", {bus.PSEL, bus.PENABLE}, 2'b11);
        check_eq("wr_paddr_n3", bus.PADDR, 32'h4);
        @(negedge PCLK);
        check_eq("wr_rsp_n4", {bus.rsp_valid, bus.rsp_write, bus.rsp_err}, 3'b110);
        check_eq("wr_slave_reg1", regs[1], 32'hDEADBEEF);

        // read 'h4: RDWAIT in N+4, rsp with data in N+5
        push(1'b0, 32'h4, 32'h0);
        repeat (3) @(negedge PCLK);
        check_eq("rd_penable_n3", {bus.PSEL, bus.PENABLE, bus.PWRITE}, 3'b110);
        @(negedge PCLK);
        check_eq("rd_rdwait_n4", {bus.PSEL, bus.rsp_valid}, 2'b00);
        @(negedge PCLK);
        check_eq("rd_rsp_n5", {bus.rsp_valid, bus.rsp_write, bus.rsp_err}, 3'b100);
        check_eq("rd_rdata_n5", bus.rsp_rdata, 32'hDEADBEEF);

        // unmapped read returns zero without error
        push(1'b0, 32'h14, 32'h0);
        wait_rsp();
        check_eq("unmapped_rdata", bus.rsp_rdata, 32'h0);
        check_eq("unmapped_err", bus.rsp_err, 1'b0);

        // misaligned command: error at N+2, no transfer, next command still runs
        push(1'b1, 32'h6, 32'h5555AAAA);
        @(negedge PCLK);
        check_eq("mis_n1", {bus.PSEL, bus.rsp_valid}, 2'b00);
        @(negedge PCLK);
        check_eq("mis_n2", {bus.PSEL, bus.rsp_valid, bus.rsp_err}, 3'b011);
        push(1'b1, 32'h8, 32'h12345678);
        wait_rsp();
        check_eq("mis_next_err", bus.rsp_err, 1'b0);
        push(1'b0, 32'h8, 32'h0);
        wait_rsp();
        check_eq("mis_next_rdata", bus.rsp_rdata, 32'h12345678);

        // back-to-back writes fill the FIFO; PSEL stays high across all of them
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) push(1'b1, 32'((i % 5) * 4), 32'hC0DE0000 + 32'(i));
            end
            begin
                bit seen;
                bit ok;
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge PCLK);
                    seen = bus.PSEL;
                end
                check(seen, "fill_psel_start", seen, 32'h1);
                ok = 1'b1;
                for (int t = 1; t < 20; t++) begin
                    @(negedge PCLK);
                    ok &= bus.PSEL;
                    if (!bus.cmd_ready) saw_full = 1'b1;
                end
                check(ok, "fill_psel_held", ok, 32'h1);
                @(negedge PCLK);
                check_eq("fill_psel_drop", bus.PSEL, 1'b0);
            end
        join
        check(saw_full, "fill_cmd_ready_low", saw_full, 32'h1);
        repeat (3) @(negedge PCLK);
        check_eq("fill_idle_busy", bus.busy, 1'b0);

        // randomized command stream
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) < 7) ? 32'($urandom_range(0, 5) * 4) : 32'($urandom_range(0, 23));
            push(1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
        for (int t = 0; t < 400 && (bus.busy || rsp_q.size() != 0); t++) @(negedge PCLK);
        check_eq("rand_drained_busy", bus.busy, 1'b0);
        check_eq("rand_drained_rsp", 32'(rsp_q.size()), 32'h0);

        // reset during ACCESS of a queued write stream
        push(1'b1, 32'h0, 32'h11111111);
        push(1'b1, 32'h4, 32'h22222222);
        push(1'b1, 32'h8, 32'h33333333);
        begin
            bit hit;
            hit = 1'b0;
            for (int t = 0; t < 20 && !hit; t++) begin
                @(negedge PCLK);
                hit = bus.PSEL && bus.PENABLE;
            end
            check(hit, "rst_found_access", hit, 32'h1);
        end
        #2 PRESETn = 1'b0;
        #1;
        check_eq("rst_async_bus", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b000);
        check_eq("rst_async_busy", bus.busy, 1'b0);
        apb_q.delete();
        rsp_q.delete();
        for (int i = 0; i < 8; i++) mmem[i] = '0;
        repeat (2) @(negedge PCLK);
        #2 PRESETn = 1'b1;
        begin
            bit quiet;
            quiet = 1'b1;
            for (int t = 0; t < 5; t++) begin
                @(negedge PCLK);
                quiet &= !bus.rsp_valid && !bus.PSEL && !bus.busy;
            end
            check(quiet, "rst_no_further_activity", quiet, 32'h1);
        end
        check_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);
        push(1'b1, 32'h0, 32'hA);
        wait_rsp();
        check_eq("rst_after_write", {bus.rsp_write, bus.rsp_err}, 2'b10);
        push(1'b0, 32'h0, 32'h0);
        wait_rsp();
        check_eq("rst_after_rdata", bus.rsp_rdata, 32'hA);
        repeat (3) @(negedge PCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
